game_sequencer: RTL
===================

# game_sequencer

Round controller for the keypad memorization game. It owns the game state machine, which runs IDLE → SHOW → ENTRY → CHECK → RESULT, then either repeats or ends in OVER. Each round it latches a 16-bit target from the random source, times the display phase, collects four keypad digits, compares them with the target, and keeps level and score. It sits between the random-number, keypad-decoder and display blocks and replaces ad-hoc phase logic at the top level.

## Interface
- SHOW_TICKS, 6: display-phase length at level 0, in `tick` periods.
- RESULT_TICKS, 2: length of the pass/fail indication, in `tick` periods.
- ENTRY_TIMEOUT, 10: number of `tick` periods without a key before the round fails (used only with the macro below).
- MAX_LEVEL, 5: saturation value of `level`.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timing strobe, e.g. 1 Hz from the clock divider.
- start  in  1  debounced one-cycle start pulse.
- rand_in  in  16  free-running random value.
- key_valid  in  1  one-cycle pulse; a keypad digit is available.
- key_value  in  4  hex digit, valid while `key_valid` is high.
- phase  out  3  current state encoding.
- target  out  16  latched target number.
- entry  out  16  digits entered so far, left-shifted in.
- digit_cnt  out  3  number of digits entered, 0..4.
- correct  out  1  result of the last CHECK.
- level  out  3  current level.
- score  out  8  rounds passed, saturating at 255.

## Operation
- Reset values: phase=IDLE; target, entry, digit_cnt, correct, level, score all 0; internal counters 0.
- IDLE:
  - `start` → SHOW.
  - On the same edge: target←rand_in, level←0, score←0, correct←0.
- SHOW:
  - On entry, the tick counter loads show_len = max(SHOW_TICKS − level, 1).
  - The counter decrements on each `tick`.
  - A `tick` while the count is 1 → ENTRY, with entry←0 and digit_cnt←0.
  - `key_valid` is ignored.
- ENTRY:
  - Each `key_valid` does entry←{entry[11:0], key_value} and digit_cnt+1.
  - The fourth accepted digit → CHECK on the next edge.
  - Keys after the fourth digit are ignored.
- CHECK (exactly one cycle):
  - correct←(entry==target).
  - If correct: score+1 (saturating at 255) and level+1 (saturating at MAX_LEVEL).
  - Always → RESULT; the tick counter loads RESULT_TICKS.
- RESULT:
  - Counts down on `tick`.
  - On expiry with correct=1: → SHOW, with target←rand_in and a fresh show_len.
  - On expiry with correct=0: → OVER.
  - Keys are ignored.
- OVER:
  - target, score and level are held for display.
  - `start` → SHOW, with the same actions as the IDLE start.
- `start` in SHOW, ENTRY, CHECK or RESULT is ignored.

## Timing
- All outputs are registered.
- `phase` changes on the clock edge after the qualifying input is sampled.
- Simultaneous `tick` and `key_valid` in ENTRY: the key is accepted, and the timeout counter reloads rather than decrementing.
- The fourth-key edge sets digit_cnt=4. `phase`=CHECK is visible one cycle later, and `correct`, `score` and `level` update one cycle after that.
- A key that arrives on the same edge SHOW→ENTRY happens is dropped; capture starts the following cycle.
- Asserting `rst` low mid-round forces all reset values immediately, regardless of `clk`.
- Counter widths: the tick counter is sized for max(SHOW_TICKS, RESULT_TICKS, ENTRY_TIMEOUT). The show_len subtraction is unsigned with a floor of 1 and must never wrap.

## Configuration
- GAME_SEQ_TIMEOUT_EN defined:
  - Entering ENTRY loads an idle counter with ENTRY_TIMEOUT, and every accepted key reloads it.
  - It decrements on `tick`.
  - A `tick` while the count is 1 forces correct←0 and → RESULT, bypassing CHECK; score and level are unchanged.
- GAME_SEQ_TIMEOUT_EN undefined: ENTRY waits indefinitely and the timeout counter is not built.

## Structure
- Shared package `game_pkg`:
  - phase encodings IDLE=0, SHOW=1, ENTRY=2, CHECK=3, RESULT=4, OVER=5;
  - the constant DIGITS=4;
  - score width 8.
- The display block decodes `phase` from the same package.
- One sub-module, `tick_timer`: a loadable down-counter with a `load` input, a load value and a `done` output (asserted on the `tick` that occurs while the count is 1). It is shared by SHOW and RESULT. When the timeout is enabled, a second instance serves as the ENTRY idle timer.

## Test plan
- Reset low mid-ENTRY → all outputs 0 and phase=IDLE in the same cycle; release, then `start` with rand_in=16'h1234 → phase=SHOW, target=16'h1234.
- Level 0, SHOW_TICKS=6 → exactly 6 `tick` pulses in SHOW, then phase=ENTRY; keys pulsed during SHOW leave entry=0.
- In ENTRY, enter digits 1,2,3,4 with target=16'h1234 → entry=16'h1234, correct=1, score=1, level=1, then after RESULT a new SHOW lasting 5 ticks.
- Enter digits 1,2,3,5 → correct=0, then OVER after 2 ticks with score held; `start` → score=0, level=0, phase=SHOW.
- Pass 7 rounds with MAX_LEVEL=5 → level saturates at 5 and show_len=1 tick; a key and a tick in the same cycle in ENTRY → digit accepted.
- With GAME_SEQ_TIMEOUT_EN, no keys for 10 ticks in ENTRY → correct=0, phase=RESULT with CHECK skipped, score unchanged; without the macro, after 50 ticks phase is still ENTRY.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the keypad memorization game: phase encoding,
// digit count, score width and the display-length helper.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW   = 3'd1,
    ENTRY  = 3'd2,
    CHECK  = 3'd3,
    RESULT = 3'd4,
    OVER   = 3'd5
  } phaseT;

  localparam int DIGITS  = 4;
  localparam int SCORE_W = 8;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Display length shrinks with level but never drops below one tick; the
  // comparison is done before subtracting so the result cannot wrap.
  function automatic int showLen(input int showTicks, input int lvl);
    if (lvl + 1 >= showTicks) return 1;
    return showTicks - lvl;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundles the game_sequencer inputs (timing, start, random, keypad) and the
// status it publishes to the display block.
interface game_sequencer_if;
  import game_pkg::*;

  logic               tick;
  logic               start;
  logic [15:0]        rand_in;
  logic               key_valid;
  logic [3:0]         key_value;

  logic [2:0]         phase;
  logic [15:0]        target;
  logic [15:0]        entry;
  logic [2:0]         digit_cnt;
  logic               correct;
  logic [2:0]         level;
  logic [SCORE_W-1:0] score;

  modport master (
    output tick, start, rand_in, key_valid, key_value,
    input  phase, target, entry, digit_cnt, correct, level, score
  );

  modport slave (
    input  tick, start, rand_in, key_valid, key_value,
    output phase, target, entry, digit_cnt, correct, level, score
  );

endinterface

// File: rtl/game_sequencer_tick_timer.sv
// Loadable down-counter stepped by the tick strobe; done fires on the tick
// that arrives while the count is 1.
module tick_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         done
);

  logic [W-1:0] count;

  // NOTE: reset is asynchronous and active-low, so it sits in the sensitivity
  // list; sequential state always uses non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = tick && (count == W'(1));

endmodule

// File: rtl/game_sequencer.sv
// Round controller: IDLE -> SHOW -> ENTRY -> CHECK -> RESULT -> (SHOW | OVER).
// Define GAME_SEQ_TIMEOUT_EN to fail a round after ENTRY_TIMEOUT idle ticks.
module game_sequencer #(
  parameter int SHOW_TICKS    = 6,
  parameter int RESULT_TICKS  = 2,
  parameter int ENTRY_TIMEOUT = 10,
  parameter int MAX_LEVEL     = 5
) (
  input  logic             clk,
  input  logic             rst,
  game_sequencer_if.slave  bus
);
  import game_pkg::*;

  localparam int TMAX = maxOf3(SHOW_TICKS, RESULT_TICKS, ENTRY_TIMEOUT);
  localparam int TW   = $clog2(TMAX + 1);

  phaseT              state;
  logic [15:0]        target;
  logic [15:0]        entry;
  logic [2:0]         digitCnt;
  logic               correct;
  logic [2:0]         level;
  logic [SCORE_W-1:0] score;

  logic               mainLoad;
  logic [TW-1:0]      mainLoadVal;
  logic               mainDone;
  logic               startGame;
  logic               keyAccept;
  logic               showDone;
  logic               resultDone;
  logic               timeoutHit;

  assign startGame  = ((state == IDLE) || (state == OVER)) && bus.start;
  assign keyAccept  = (state == ENTRY) && bus.key_valid && (digitCnt < 3'(DIGITS));
  assign showDone   = (state == SHOW) && mainDone;
  assign resultDone = (state == RESULT) && mainDone;

  // One timer serves both SHOW and RESULT; it is loaded on the edge that
  // enters each phase so the new length is counted from the next tick.
  // NOTE: every output of this always_comb gets a default first, so no latch.
  always_comb begin
    mainLoad    = 1'b0;
    mainLoadVal = '0;
    if (startGame) begin
      mainLoad    = 1'b1;
      mainLoadVal = TW'(showLen(SHOW_TICKS, 0));
    end else if (resultDone && correct) begin
      mainLoad    = 1'b1;
      mainLoadVal = TW'(showLen(SHOW_TICKS, int'(level)));
    end else if ((state == CHECK) || timeoutHit) begin
      mainLoad    = 1'b1;
      mainLoadVal = TW'(RESULT_TICKS);
    end
  end

  tick_timer #(.W(TW)) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .tick    (bus.tick),
    .load    (mainLoad),
    .loadVal (mainLoadVal),
    .done    (mainDone)
  );

`ifdef GAME_SEQ_TIMEOUT_EN
  logic idleDone;

  // A key on the same edge as a tick reloads the idle timer instead of
  // letting it expire.
  tick_timer #(.W(TW)) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .tick    (bus.tick),
    .load    (showDone || keyAccept),
    .loadVal (TW'(ENTRY_TIMEOUT)),
    .done    (idleDone)
  );

  assign timeoutHit = (state == ENTRY) && idleDone && !keyAccept &&
                      (digitCnt < 3'(DIGITS));
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      target   <= '0;
      entry    <= '0;
      digitCnt <= '0;
      correct  <= 1'b0;
      level    <= '0;
      score    <= '0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (bus.start) begin
            state   <= SHOW;
            target  <= bus.rand_in;
            level   <= '0;
            score   <= '0;
            correct <= 1'b0;
          end
        end

        SHOW: begin
          if (mainDone) begin
            state    <= ENTRY;
            entry    <= '0;
            digitCnt <= '0;
          end
        end

        ENTRY: begin
          if (digitCnt == 3'(DIGITS)) begin
            state <= CHECK;
          end else if (timeoutHit) begin
            correct <= 1'b0;
            state   <= RESULT;
          end else if (keyAccept) begin
            entry    <= {entry[11:0], bus.key_value};
            digitCnt <= digitCnt + 3'd1;
          end
        end

        CHECK: begin
          correct <= (entry == target);
          if (entry == target) begin
            if (score != '1)               score <= score + SCORE_W'(1);
            if (level < 3'(MAX_LEVEL))     level <= level + 3'd1;
          end
          state <= RESULT;
        end

        RESULT: begin
          if (mainDone) begin
            if (correct) begin
              state  <= SHOW;
              target <= bus.rand_in;
            end else begin
              state <= OVER;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.phase     = state;
  assign bus.target    = target;
  assign bus.entry     = entry;
  assign bus.digit_cnt = digitCnt;
  assign bus.correct   = correct;
  assign bus.level     = level;
  assign bus.score     = score;

endmodule
